// File: rtl/bf_unit_pipe_if.sv
// Streaming handshake bundle for bf_unit_pipe: sample-in channel, result-out channel and busy flag.
interface bf_unit_pipe_if #(
  parameter int DATA_WIDTH = 14
);
  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            mode;
  logic [DATA_WIDTH-1:0] u;
  logic [DATA_WIDTH-1:0] v;
  logic [DATA_WIDTH-1:0] w;
  logic                  out_ready;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] bf_upper;
  logic [DATA_WIDTH-1:0] bf_lower;
  logic                  busy;

  modport master (
    output in_valid, mode, u, v, w, out_ready,
    input  in_ready, out_valid, bf_upper, bf_lower, busy
  );

  modport slave (
    input  in_valid, mode, u, v, w, out_ready,
    output in_ready, out_valid, bf_upper, bf_lower, busy
  );
endinterface

// File: rtl/bf_unit_pipe.sv
// Fully pipelined modular butterfly (CT / GS / pointwise multiply / add-sub), fixed latency MUL_LAT+2.
// Optional macro HALF_SCALE_EN: GS results are multiplied by 2^-1 mod Q in the final stage.

// Barrett modular multiplier, result in [0,Q) after exactly MUL_LAT enabled cycles.
module bf_unit_pipe_modmul #(
  parameter int DATA_WIDTH = 14,
  parameter int Q          = 12289,
  parameter int MUL_LAT    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [DATA_WIDTH-1:0] o_res
);
  localparam int              PW        = 2 * DATA_WIDTH;
  localparam logic [PW:0]     ONE_K     = {1'b1, {PW{1'b0}}};
  localparam logic [PW:0]     BARRETT_M = ONE_K / (PW+1)'(Q);
  localparam logic [PW+1:0]   Q_X       = (PW+2)'(Q);
  localparam logic [PW+1:0]   Q2_X      = Q_X << 1;

  // floor(p*M / 2^PW) undershoots the true quotient by at most 2, so the remainder is below 3Q.
  function automatic logic [PW:0] quotEst(input logic [PW-1:0] p);
    logic [2*PW+1:0] t;
    t = {{(PW+2){1'b0}}, p} * {{(PW+1){1'b0}}, BARRETT_M};
    return (PW+1)'(t >> PW);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] fold(input logic [PW-1:0] p, input logic [PW:0] qe);
    logic [PW+1:0] r;
    r = {2'b00, p} - ({1'b0, qe} * Q_X);
    if (r >= Q2_X)
      r = r - Q2_X;
    else if (r >= Q_X)
      r = r - Q_X;
    return DATA_WIDTH'(r);
  endfunction

  logic [PW-1:0] w_prod;
  assign w_prod = {{DATA_WIDTH{1'b0}}, i_a} * {{DATA_WIDTH{1'b0}}, i_b};

  generate
    if (MUL_LAT == 1) begin : g_lat1
      logic [DATA_WIDTH-1:0] r_res;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          r_res <= '0;
        else if (i_en)
          r_res <= fold(w_prod, quotEst(w_prod));
      end
      assign o_res = r_res;
    end else if (MUL_LAT == 2) begin : g_lat2
      logic [PW-1:0]         r_prod;
      logic [DATA_WIDTH-1:0] r_res;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_prod <= '0;
          r_res  <= '0;
        end else if (i_en) begin
          r_prod <= w_prod;
          r_res  <= fold(r_prod, quotEst(r_prod));
        end
      end
      assign o_res = r_res;
    end else begin : g_latN
      // product, quotient estimate and correction each get a stage; surplus depth is a plain delay
      logic [PW-1:0]         r_prod;
      logic [PW-1:0]         r_prodDly;
      logic [PW:0]           r_quot;
      logic [DATA_WIDTH-1:0] r_res [MUL_LAT-2];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_prod    <= '0;
          r_prodDly <= '0;
          r_quot    <= '0;
          for (int i = 0; i < MUL_LAT-2; i++)
            r_res[i] <= '0;
        end else if (i_en) begin
          r_prod    <= w_prod;
          r_prodDly <= r_prod;
          r_quot    <= quotEst(r_prod);
          r_res[0]  <= fold(r_prodDly, r_quot);
          for (int i = 1; i < MUL_LAT-2; i++)
            r_res[i] <= r_res[i-1];
        end
      end
      assign o_res = r_res[MUL_LAT-3];
    end
  endgenerate
endmodule

module bf_unit_pipe #(
  parameter int DATA_WIDTH = 14,
  parameter int Q          = 12289,
  parameter int MUL_LAT    = 4
) (
  input  logic         clk,
  input  logic         rst,
  bf_unit_pipe_if.slave bus
);
  localparam int                  L    = MUL_LAT + 2;
  localparam int                  LAST = L - 1;
  localparam int                  PRE  = L - 2;
  localparam logic [DATA_WIDTH:0] Q_E  = (DATA_WIDTH+1)'(Q);

  typedef enum logic [1:0] {
    MODE_CT     = 2'b00,
    MODE_GS     = 2'b01,
    MODE_PWM    = 2'b10,
    MODE_ADDSUB = 2'b11
  } mode_t;

  function automatic logic [DATA_WIDTH-1:0] modAdd(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= Q_E)
      s = s - Q_E;
    return DATA_WIDTH'(s);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] modSub(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[DATA_WIDTH])
      d = d + Q_E;
    return DATA_WIDTH'(d);
  endfunction

`ifdef HALF_SCALE_EN
  // x * 2^-1 mod Q: odd values borrow Q (odd) so the shift is exact
  function automatic logic [DATA_WIDTH-1:0] halve(input logic [DATA_WIDTH-1:0] x);
    logic [DATA_WIDTH:0] t;
    t = x[0] ? ({1'b0, x} + Q_E) : {1'b0, x};
    return DATA_WIDTH'(t >> 1);
  endfunction
`endif

  logic                  w_adv;
  logic                  w_accept;
  logic [L-1:0]          r_vld;
  mode_t                 r_mode   [L];
  logic [DATA_WIDTH-1:0] r_uPipe  [L-1];
  logic [DATA_WIDTH-1:0] r_vPipe  [L-1];
  logic [DATA_WIDTH-1:0] r_w0;
  logic [DATA_WIDTH-1:0] r_gsDiff;
  logic [DATA_WIDTH-1:0] r_gsW;
  logic [DATA_WIDTH-1:0] r_up;
  logic [DATA_WIDTH-1:0] r_lo;
  logic [DATA_WIDTH-1:0] w_prodA;
  logic [DATA_WIDTH-1:0] w_prodB;
  logic [DATA_WIDTH-1:0] w_addOp;
  logic [DATA_WIDTH-1:0] w_sum;
  logic [DATA_WIDTH-1:0] w_diff;
  logic [DATA_WIDTH-1:0] w_upNext;
  logic [DATA_WIDTH-1:0] w_loNext;
  logic [DATA_WIDTH-1:0] w_gsLower;

  // One global enable: every stage moves only when the output slot is free or being drained.
  assign w_adv    = bus.out_ready | ~r_vld[LAST];
  assign w_accept = bus.in_valid & w_adv;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld <= '0;
      for (int i = 0; i < L; i++)
        r_mode[i] <= MODE_CT;
    end else if (w_adv) begin
      r_vld     <= {r_vld[L-2:0], w_accept};
      r_mode[0] <= mode_t'(bus.mode);
      for (int i = 1; i < L; i++)
        r_mode[i] <= r_mode[i-1];
    end
  end

  // u and v ride alongside multiplier A so the final add/sub stage sees them aligned with v*w.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < L-1; i++) begin
        r_uPipe[i] <= '0;
        r_vPipe[i] <= '0;
      end
      r_w0 <= '0;
    end else if (w_adv) begin
      r_uPipe[0] <= bus.u;
      r_vPipe[0] <= bus.v;
      for (int i = 1; i < L-1; i++) begin
        r_uPipe[i] <= r_uPipe[i-1];
        r_vPipe[i] <= r_vPipe[i-1];
      end
      r_w0 <= bus.w;
    end
  end

  // GS needs u-v before its multiply, so it enters multiplier B one stage later than CT enters A.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gsDiff <= '0;
      r_gsW    <= '0;
    end else if (w_adv) begin
      r_gsDiff <= modSub(r_uPipe[0], r_vPipe[0]);
      r_gsW    <= r_w0;
    end
  end

  bf_unit_pipe_modmul #(.DATA_WIDTH(DATA_WIDTH), .Q(Q), .MUL_LAT(MUL_LAT)) u_mulA (
    .clk   (clk),
    .rst_n (rst),
    .i_en  (w_adv),
    .i_a   (r_vPipe[0]),
    .i_b   (r_w0),
    .o_res (w_prodA)
  );

  bf_unit_pipe_modmul #(.DATA_WIDTH(DATA_WIDTH), .Q(Q), .MUL_LAT(MUL_LAT)) u_mulB (
    .clk   (clk),
    .rst_n (rst),
    .i_en  (w_adv),
    .i_a   (r_gsDiff),
    .i_b   (r_gsW),
    .o_res (w_prodB)
  );

  assign w_addOp = (r_mode[PRE] == MODE_CT) ? w_prodA : r_vPipe[PRE];
  assign w_sum   = modAdd(r_uPipe[PRE], w_addOp);
  assign w_diff  = modSub(r_uPipe[PRE], w_addOp);

  always_comb begin
    w_upNext = w_sum;
    w_loNext = w_diff;
    case (r_mode[PRE])
      MODE_GS: begin
`ifdef HALF_SCALE_EN
        w_upNext = halve(w_sum);
`endif
        w_loNext = '0;
      end
      MODE_PWM: begin
        w_upNext = w_prodA;
        w_loNext = r_uPipe[PRE];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_up <= '0;
      r_lo <= '0;
    end else if (w_adv) begin
      r_up <= w_upNext;
      r_lo <= w_loNext;
    end
  end

`ifdef HALF_SCALE_EN
  assign w_gsLower = halve(w_prodB);
`else
  assign w_gsLower = w_prodB;
`endif

  // GS lower comes straight from multiplier B's last register, which shares the output stage.
  assign bus.bf_upper  = r_up;
  assign bus.bf_lower  = (r_mode[LAST] == MODE_GS) ? w_gsLower : r_lo;
  assign bus.out_valid = r_vld[LAST];
  assign bus.busy      = |r_vld;
  assign bus.in_ready  = w_adv;
endmodule

// File: tb/tb_bf_unit_pipe.sv
// Self-checking bench for bf_unit_pipe: vector table, mixed-mode stream, stall and mid-stream reset.
module tb_bf_unit_pipe;
  localparam int DW      = 14;
  localparam int Q       = 12289;
  localparam int MUL_LAT = 4;
  localparam int L       = MUL_LAT + 2;

  localparam logic [1:0] M_CT = 2'b00, M_GS = 2'b01, M_PWM = 2'b10, M_AS = 2'b11;

  logic clk;
  logic rst;

  bf_unit_pipe_if #(.DATA_WIDTH(DW)) bus();

  bf_unit_pipe #(.DATA_WIDTH(DW), .Q(Q), .MUL_LAT(MUL_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int up;
    int lo;
    int cyc;
    bit chkLat;
    bit anyVal;
  } exp_t;

  typedef struct {
    logic [1:0] mode;
    int u;
    int v;
    int w;
    int expUp;
    int expLo;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[13];
  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic int halfMod(input int x);
    return (x % 2 == 0) ? x / 2 : (x + Q) / 2;
  endfunction

  task automatic golden(input logic [1:0] m, input int u, input int v, input int w,
                        output int up, output int lo);
    longint p;
    p = (longint'(v) * longint'(w)) % Q;
    case (m)
      M_CT: begin
        up = int'((u + p) % Q);
        lo = int'((u - p + Q) % Q);
      end
      M_GS: begin
        up = (u + v) % Q;
        lo = int'((longint'((u - v + Q) % Q) * longint'(w)) % Q);
`ifdef HALF_SCALE_EN
        up = halfMod(up);
        lo = halfMod(lo);
`endif
      end
      M_PWM: begin
        up = int'(p);
        lo = u;
      end
      default: begin
        up = (u + v) % Q;
        lo = (u - v + Q) % Q;
      end
    endcase
  endtask

  // Holds a sample on the bus until accepted, then records its expectation with the accept cycle.
  task automatic applyStimulus(input logic [1:0] m, input int u, input int v, input int w,
                               input int expUp, input int expLo, input bit chkLat, input bit anyVal);
    int   waited;
    bit   done;
    exp_t e;
    waited       = 0;
    done         = 1'b0;
    bus.in_valid = 1'b1;
    bus.mode     = m;
    bus.u        = u[DW-1:0];
    bus.v        = v[DW-1:0];
    bus.w        = w[DW-1:0];
    while (!done) begin
      @(negedge clk);
      if (rst && bus.in_ready) begin
        e.up = expUp; e.lo = expLo; e.cyc = cyc; e.chkLat = chkLat; e.anyVal = anyVal;
        sb.push_back(e);
        done = 1'b1;
      end else begin
        waited++;
        if (waited > 100) begin
          checks++;
          errors++;
          $display("[TB] FAIL accept timeout: waited %0d cycles, required acceptance within 100", waited);
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.busy) && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain timeout: %0d results outstanding, required 0", sb.size());
    end
    #1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected beat: got upper=%0d lower=%0d, required no output",
                 bus.bf_upper, bus.bf_lower);
      end else begin
        e = sb.pop_front();
        if (e.anyVal) begin
          checkOutput("oob upper unknown", {31'b0, $isunknown(bus.bf_upper)}, 32'd0);
          checkOutput("oob lower unknown", {31'b0, $isunknown(bus.bf_lower)}, 32'd0);
        end else begin
          checkOutput("upper", {18'b0, bus.bf_upper}, e.up);
          checkOutput("lower", {18'b0, bus.bf_lower}, e.lo);
        end
        if (e.chkLat)
          checkOutput("latency", cyc - e.cyc, L);
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL global timeout: simulation still running, required completion");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int eu, el, n;

    vecs[0]  = '{M_CT,  5,     3,     2,     11,    12288};
    vecs[1]  = '{M_GS,  12288, 2,     3,     1,     12280};
    vecs[2]  = '{M_PWM, 77,    12288, 12288, 1,     77};
    vecs[3]  = '{M_AS,  10,    12285, 0,     6,     14};
    vecs[4]  = '{M_CT,  0,     12288, 12288, 1,     12288};
    vecs[5]  = '{M_CT,  12288, 0,     500,   12288, 12288};
    vecs[6]  = '{M_GS,  0,     0,     9999,  0,     0};
    vecs[7]  = '{M_AS,  6000,  6289,  7,     0,     12000};
    vecs[8]  = '{M_PWM, 0,     12288, 2,     12287, 0};
    vecs[9]  = '{M_GS,  3,     7,     12288, 10,    4};
    vecs[10] = '{M_CT,  12288, 12288, 12288, 0,     12287};
    vecs[11] = '{M_PWM, 1234,  111,   111,   32,    1234};
    vecs[12] = '{M_CT,  0,     12000, 12000, 9787,  2502};
`ifdef HALF_SCALE_EN
    vecs[1].expUp = 6145;  vecs[1].expLo = 6140;
    vecs[9].expUp = 5;     vecs[9].expLo = 2;
`endif

    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.mode      = 2'b00;
    bus.u         = '0;
    bus.v         = '0;
    bus.w         = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset out_valid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("reset busy",      {31'b0, bus.busy},      32'd0);
    checkOutput("reset upper",     {18'b0, bus.bf_upper},  32'd0);
    checkOutput("reset lower",     {18'b0, bus.bf_lower},  32'd0);
    checkOutput("reset in_ready",  {31'b0, bus.in_ready},  32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] vector table, back-to-back");
    for (int i = 0; i < 13; i++)
      applyStimulus(vecs[i].mode, vecs[i].u, vecs[i].v, vecs[i].w, vecs[i].expUp, vecs[i].expLo, 1'b1, 1'b0);
    waitDrain();

    $display("[TB] mixed-mode stream with one bubble");
    for (int i = 0; i < 8; i++) begin
      int u, v, w;
      u = int'($urandom_range(Q-1, 0));
      v = int'($urandom_range(Q-1, 0));
      w = int'($urandom_range(Q-1, 0));
      golden(2'(i % 4), u, v, w, eu, el);
      applyStimulus(2'(i % 4), u, v, w, eu, el, 1'b1, 1'b0);
      if (i == 4) begin
        @(posedge clk);
        #1;
      end
    end
    waitDrain();

    $display("[TB] output stall for 3 cycles");
    fork
      begin : sendStream
        int su, sv, sw, seu, sel;
        for (int i = 0; i < 8; i++) begin
          su = int'($urandom_range(Q-1, 0));
          sv = int'($urandom_range(Q-1, 0));
          sw = int'($urandom_range(Q-1, 0));
          golden(2'(i % 4), su, sv, sw, seu, sel);
          applyStimulus(2'(i % 4), su, sv, sw, seu, sel, 1'b0, 1'b0);
        end
      end
      begin : stallCtl
        int k;
        k = 0;
        @(negedge clk);
        while (!bus.out_valid && k < 50) begin
          @(negedge clk);
          k++;
        end
        checkOutput("stall first beat seen", {31'b0, bus.out_valid}, 32'd1);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          checkOutput("stall in_ready",  {31'b0, bus.in_ready},  32'd0);
          checkOutput("stall out_valid", {31'b0, bus.out_valid}, 32'd1);
          if (sb.size() != 0) begin
            checkOutput("stall held upper", {18'b0, bus.bf_upper}, sb[0].up);
            checkOutput("stall held lower", {18'b0, bus.bf_lower}, sb[0].lo);
          end
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    waitDrain();

    $display("[TB] out-of-range operands");
    applyStimulus(M_CT, 16383, 16383, 16383, 0, 0, 1'b0, 1'b1);
    applyStimulus(M_GS, 16383, 12289, 16383, 0, 0, 1'b0, 1'b1);
    waitDrain();

    $display("[TB] reset with samples in flight");
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      golden(M_CT, 1000 + i, 2000 + i, 3000 + i, eu, el);
      applyStimulus(M_CT, 1000 + i, 2000 + i, 3000 + i, eu, el, 1'b0, 1'b0);
    end
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("pre-reset out_valid", {31'b0, bus.out_valid}, 32'd1);
    checkOutput("pre-reset busy",      {31'b0, bus.busy},      32'd1);
    if (sb.size() != 0)
      checkOutput("pre-reset head upper", {18'b0, bus.bf_upper}, sb[0].up);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async reset out_valid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("async reset busy",      {31'b0, bus.busy},      32'd0);
    checkOutput("async reset upper",     {18'b0, bus.bf_upper},  32'd0);
    checkOutput("async reset lower",     {18'b0, bus.bf_lower},  32'd0);
    checkOutput("async reset in_ready",  {31'b0, bus.in_ready},  32'd1);
    sb.delete();
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(M_CT, 100, 200, 300, 10944, 1545, 1'b1, 1'b0);
    waitDrain();

    checkOutput("scoreboard empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
